jogo_memoria_param: RTL

- Parametrised memory-sequence game core ("genius" style), successor to the fixed 4-button, 16-round circuit. Depth, button count and timeout are generic.
- Shows a first play on the LEDs. Each round the player repeats the stored sequence, then inserts a new play, which is written into internal RAM.
- Ends in win, lose or timeout.
- Sits under the board top. The debug outputs feed the hex decoders.

---
 rtl/jogo_pkg.sv | 27 ++
 rtl/ram_jogadas.sv | 33 +++
 rtl/jogo_memoria_param.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised memory-sequence game: state codes
// and the one-hot test applied to every registered play.
package jogo_pkg;

  // State codes are visible on db_estado and drive the board hex decoders.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    ESPERA      = 4'h3,
    COMPARA     = 4'h4,
    ESPERA_NOVA = 4'h5,
    ESCREVE     = 4'h6,
    FIM_GANHOU  = 4'hA,
    FIM_PERDEU  = 4'hE,
    FIM_TIMEOUT = 4'hF
  } estado_t;

  // Widest button bank supported; narrower plays are zero-extended.
  localparam int MAX_BOTOES = 8;

  // True when exactly one bit of v is set.
  function automatic logic eh_one_hot(input logic [MAX_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction

endpackage

// File: rtl/ram_jogadas.sv
// Play memory: DEPTH words of N_BOTOES bits. Synchronous write, asynchronous
// read. Word 0 holds the first play and is reloaded on every reset.
module ram_jogadas
  import jogo_pkg::*;
#(
  parameter int                  N_BOTOES        = 4,
  parameter int                  DEPTH           = 16,
  parameter logic [N_BOTOES-1:0] PRIMEIRA_JOGADA = {{(N_BOTOES-1){1'b0}}, 1'b1},
  parameter int                  AW              = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [N_BOTOES-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [N_BOTOES-1:0] o_rdata
);

  logic [N_BOTOES-1:0] r_mem [DEPTH];

  // Reset only restores word 0; the rest is rewritten before it is ever read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem[0] <= PRIMEIRA_JOGADA;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory-sequence game core. Shows the first play, then each round the player
// repeats the stored sequence and appends a new play. Ends in win, lose or
// timeout; iniciar from any final state starts a new game.
//
// Play detection: a play is the 0 -> non-zero transition of OR(botoes),
// measured against the OR registered on the previous cycle. r_tem_jogada is
// high for exactly one cycle per play and r_jogada is loaded on that same
// edge, so both are valid together during the following cycle. Holding or
// releasing a button never creates another play.
module jogo_memoria_param
  import jogo_pkg::*;
#(
  parameter int                  N_BOTOES        = 4,
  parameter int                  DEPTH           = 16,
  parameter logic [N_BOTOES-1:0] PRIMEIRA_JOGADA = {{(N_BOTOES-1){1'b0}}, 1'b1},
  parameter int                  MOSTRA_CICLOS   = 2000,
  parameter int                  TIMEOUT_CICLOS  = 5000,
  parameter int                  TIMEOUT_EN      = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic [N_BOTOES-1:0]       botoes,
  output logic [N_BOTOES-1:0]       leds,
  output logic                      pronto,
  output logic                      ganhou,
  output logic                      perdeu,
  output logic                      db_timeout,
  output logic [3:0]                db_estado,
  output logic [$clog2(DEPTH)-1:0]  db_rodada,
  output logic [$clog2(DEPTH)-1:0]  db_endereco,
  output logic [N_BOTOES-1:0]       db_jogada
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_LIM = (MOSTRA_CICLOS > TIMEOUT_CICLOS) ? MOSTRA_CICLOS : TIMEOUT_CICLOS;
  localparam int CNT_W   = $clog2(CNT_LIM + 1);

  localparam logic [AW-1:0]    ULTIMA_RODADA = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FIM_MOSTRA    = CNT_W'(MOSTRA_CICLOS - 1);
  localparam logic [CNT_W-1:0] FIM_TEMPO     = CNT_W'(TIMEOUT_CICLOS - 1);

  estado_t             r_estado;
  estado_t             w_proximo;
  logic                r_or_prev;
  logic                r_tem_jogada;
  logic [N_BOTOES-1:0] r_jogada;
  logic [AW-1:0]       r_rodada;
  logic [AW-1:0]       r_endereco;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_or_botoes;
  logic                w_borda;
  logic                w_jogada_valida;
  logic                w_jogada_ok;
  logic                w_em_espera;
  logic                w_tempo_esgotado;
  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic [N_BOTOES-1:0] w_dado_ram;

  assign w_or_botoes      = |botoes;
  assign w_borda          = w_or_botoes & ~r_or_prev;
  assign w_jogada_valida  = eh_one_hot(MAX_BOTOES'(r_jogada));
  assign w_jogada_ok      = w_jogada_valida && (r_jogada == w_dado_ram);
  assign w_em_espera      = (r_estado == ESPERA) || (r_estado == ESPERA_NOVA);
  assign w_tempo_esgotado = (TIMEOUT_EN != 0) && (r_cnt == FIM_TEMPO);
  assign w_we             = (r_estado == ESCREVE);
  assign w_waddr          = r_rodada + AW'(1);

  ram_jogadas #(
    .N_BOTOES        (N_BOTOES),
    .DEPTH           (DEPTH),
    .PRIMEIRA_JOGADA (PRIMEIRA_JOGADA)
  ) u_ram (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_jogada),
    .i_raddr (r_endereco),
    .o_rdata (w_dado_ram)
  );

  // Edge detector on OR(botoes); the play value is captured with the pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_or_prev    <= 1'b0;
      r_tem_jogada <= 1'b0;
      r_jogada     <= '0;
    end else begin
      r_or_prev    <= w_or_botoes;
      r_tem_jogada <= w_borda;
      if (w_borda) r_jogada <= botoes;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_proximo;
  end

  // Next-state logic; a play arriving on the timeout cycle takes priority.
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      INICIAL:     if (iniciar) w_proximo = PREPARA;
      PREPARA:     w_proximo = MOSTRA;
      MOSTRA:      if (r_cnt == FIM_MOSTRA) w_proximo = ESPERA;
      ESPERA: begin
        if (r_tem_jogada)          w_proximo = COMPARA;
        else if (w_tempo_esgotado) w_proximo = FIM_TIMEOUT;
      end
      COMPARA: begin
        if (!w_jogada_ok)                     w_proximo = FIM_PERDEU;
        else if (r_endereco < r_rodada)       w_proximo = ESPERA;
        else if (r_rodada == ULTIMA_RODADA)   w_proximo = FIM_GANHOU;
        else                                  w_proximo = ESPERA_NOVA;
      end
      ESPERA_NOVA: begin
        if (r_tem_jogada)          w_proximo = w_jogada_valida ? ESCREVE : FIM_PERDEU;
        else if (w_tempo_esgotado) w_proximo = FIM_TIMEOUT;
      end
      ESCREVE:     w_proximo = ESPERA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (iniciar) w_proximo = PREPARA;
      default:     w_proximo = INICIAL;
    endcase
  end

  // Round/address counters and the shared display/timeout cycle counter.
  // The cycle counter restarts on every state change and on every play, and
  // saturates so it cannot wrap while timeout detection is disabled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rodada   <= '0;
      r_endereco <= '0;
      r_cnt      <= '0;
    end else begin
      if ((w_proximo != r_estado) || (w_em_espera && r_tem_jogada)) r_cnt <= '0;
      else if (r_cnt != '1)                                          r_cnt <= r_cnt + CNT_W'(1);

      case (r_estado)
        PREPARA: begin
          r_rodada   <= '0;
          r_endereco <= '0;
        end
        COMPARA: if (w_jogada_ok && (r_endereco < r_rodada)) r_endereco <= r_endereco + AW'(1);
        ESCREVE: begin
          r_rodada   <= r_rodada + AW'(1);
          r_endereco <= '0;
        end
        default: ;
      endcase
    end
  end

  // LEDs show the first play while displaying it, otherwise echo the buttons.
  always_comb begin
    leds = botoes;
    if (r_estado == MOSTRA) leds = w_dado_ram;
  end

  assign pronto      = (r_estado == FIM_GANHOU) || (r_estado == FIM_PERDEU) || (r_estado == FIM_TIMEOUT);
  assign ganhou      = (r_estado == FIM_GANHOU);
  assign perdeu      = (r_estado == FIM_PERDEU) || (r_estado == FIM_TIMEOUT);
  assign db_timeout  = (r_estado == FIM_TIMEOUT);
  assign db_estado   = r_estado;
  assign db_rodada   = r_rodada;
  assign db_endereco = r_endereco;
  assign db_jogada   = r_jogada;

endmodule
